cdc_handshake_sync: RTL and testbench

Parametrised two-clock data transfer block. It moves a WIDTH-bit word from the clk2 source domain into the clk1 destination domain using a toggle req/ack handshake with multi-flop synchronisers. Each side has a valid/ready interface. A wrapping transfer counter runs in clk1. It is the next generation of the team's dual-clock capture flops: those flops register each domain independently and have no crossing protection, which this block adds.

---
 rtl/cdc_handshake_sync.sv | 125 ++++++++++++
 tb/tb_cdc_handshake_sync.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_sync.sv
// rtl/cdc_handshake_sync.sv - toggle req/ack word transfer from clk2 into clk1 with a wrapping transfer counter
// Optional parity check on the crossing word is enabled by defining CDC_PARITY_EN.
module cdc_handshake_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk1,
  input  logic             reset_n,
  input  logic             clk2,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             src_ready,
  output logic             dst_valid,
  output logic [WIDTH-1:0] dst_data,
  input  logic             dst_ready,
  output logic             dst_perr,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic {S_IDLE, S_BUSY} src_state_t;
  typedef enum logic {D_WAIT, D_VALID} dst_state_t;

  src_state_t             src_state;
  dst_state_t             dst_state;
  logic [WIDTH-1:0]       hold_data;
  logic                   req_tgl;
  logic                   ack_tgl;
  logic [SYNC_STAGES-1:0] req_sync_q;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   req_sync;
  logic                   ack_sync;

  assign req_sync = req_sync_q[SYNC_STAGES-1];
  assign ack_sync = ack_sync_q[SYNC_STAGES-1];

`ifdef CDC_PARITY_EN
  logic hold_par;
`endif

  // Source side: hold_data stays frozen from accept until the ack toggle returns.
  always_ff @(posedge clk2 or negedge reset_n) begin
    if (!reset_n) begin
      src_state  <= S_IDLE;
      src_ready  <= 1'b1;
      hold_data  <= '0;
      req_tgl    <= 1'b0;
      ack_sync_q <= '0;
`ifdef CDC_PARITY_EN
      hold_par   <= 1'b0;
`endif
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_tgl};
      case (src_state)
        S_IDLE: begin
          if (src_valid) begin
            hold_data <= src_data;
            req_tgl   <= ~req_tgl;
`ifdef CDC_PARITY_EN
            hold_par  <= ^src_data;
`endif
            src_ready <= 1'b0;
            src_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (ack_sync == req_tgl) begin
            src_ready <= 1'b1;
            src_state <= S_IDLE;
          end
        end
        default: begin
          src_ready <= 1'b1;
          src_state <= S_IDLE;
        end
      endcase
    end
  end

  // Destination side: hold_data is sampled unsynchronised once req has crossed.
  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      dst_state  <= D_WAIT;
      dst_valid  <= 1'b0;
      dst_data   <= '0;
      ack_tgl    <= 1'b0;
      xfer_cnt   <= '0;
      req_sync_q <= '0;
`ifdef CDC_PARITY_EN
      dst_perr   <= 1'b0;
`endif
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_tgl};
      case (dst_state)
        D_WAIT: begin
          if (req_sync != ack_tgl) begin
            dst_data  <= hold_data;
`ifdef CDC_PARITY_EN
            dst_perr  <= (^hold_data) ^ hold_par;
`endif
            dst_valid <= 1'b1;
            dst_state <= D_VALID;
          end
        end
        D_VALID: begin
          if (dst_ready) begin
            ack_tgl   <= ~ack_tgl;
            xfer_cnt  <= xfer_cnt + 1'b1;
            dst_valid <= 1'b0;
            dst_state <= D_WAIT;
          end
        end
        default: begin
          dst_valid <= 1'b0;
          dst_state <= D_WAIT;
        end
      endcase
    end
  end

`ifndef CDC_PARITY_EN
  assign dst_perr = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_sync.sv
// tb/tb_cdc_handshake_sync.sv - directed bench for cdc_handshake_sync
// Parity scenario follows CDC_PARITY_EN as defined for the build.
`timescale 1ns/10ps
module tb_cdc_handshake_sync;

  localparam int SS    = 2;
  localparam int N_STR = 300;

  logic       clk1 = 1'b0;
  logic       clk2 = 1'b0;
  logic       reset_n = 1'b0;
  logic       src_valid = 1'b0;
  logic [7:0] src_data = 8'h00;
  logic       src_ready;
  logic       dst_valid;
  logic [7:0] dst_data;
  logic       dst_ready = 1'b1;
  logic       dst_perr;
  logic [7:0] xfer_cnt;

  realtime h1 = 5.0;
  realtime h2 = 6.5;

  int vectors = 0;
  int miscompares = 0;

  cdc_handshake_sync #(.WIDTH(8), .SYNC_STAGES(SS), .CNT_W(8)) dut (
    .clk1(clk1), .reset_n(reset_n), .clk2(clk2),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .dst_valid(dst_valid), .dst_data(dst_data), .dst_ready(dst_ready),
    .dst_perr(dst_perr), .xfer_cnt(xfer_cnt)
  );

  // clk2 is offset so its edges never coincide with clk1 edges
  always #(h1) clk1 = ~clk1;
  initial begin
    #0.3;
    forever #(h2) clk2 = ~clk2;
  end

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (4) @(posedge clk1);
    #0.1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk1);
    #0.1;
  endtask

  // Offers one word and returns 0.1 ns after the accept edge.
  task automatic send_word(input logic [7:0] d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (src_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk2);
      #0.1;
    end
    if (ok) begin
      src_valid = 1'b1;
      src_data  = d;
      @(posedge clk2);
      #0.1;
      src_valid = 1'b0;
    end
  endtask

  task automatic wait_dst(output int n);
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk1);
      #0.1;
      if (dst_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if (src_ready !== 1'b1) begin miscompares++; $display("FAIL reset_src_ready got %b want 1", src_ready); end
    vectors++;
    if (dst_valid !== 1'b0) begin miscompares++; $display("FAIL reset_dst_valid got %b want 0", dst_valid); end
    vectors++;
    if (xfer_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_xfer_cnt got %0d want 0", xfer_cnt); end
    vectors++;
    if (dst_data !== 8'h00) begin miscompares++; $display("FAIL reset_dst_data got %h want 00", dst_data); end
    vectors++;
    if (dst_perr !== 1'b0) begin miscompares++; $display("FAIL reset_dst_perr got %b want 0", dst_perr); end
  endtask

  task automatic test_single();
    bit ok;
    int n;
    dst_ready = 1'b1;
    send_word(8'hA5, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL single_accept got timeout want accept"); end
    wait_dst(n);
    vectors++;
    if (n < SS + 1 || n > SS + 2) begin
      miscompares++; $display("FAIL single_latency got %0d edges want %0d..%0d", n, SS + 1, SS + 2);
    end
    vectors++;
    if (dst_data !== 8'hA5) begin miscompares++; $display("FAIL single_data got %h want a5", dst_data); end
    @(posedge clk1);
    #0.1;
    vectors++;
    if (dst_valid !== 1'b0) begin miscompares++; $display("FAIL single_pulse got %b want 0", dst_valid); end
    vectors++;
    if (xfer_cnt !== 8'd1) begin miscompares++; $display("FAIL single_cnt got %0d want 1", xfer_cnt); end
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk2);
      #0.1;
      if (src_ready) begin n = i; break; end
    end
    vectors++;
    if (n == 0) begin miscompares++; $display("FAIL single_src_ready got 0 want 1"); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    int bad;
    dst_ready = 1'b0;
    send_word(8'h3C, ok);
    wait_dst(n);
    vectors++;
    if (!ok || n == 0) begin miscompares++; $display("FAIL bp_arrive got ok=%b n=%0d want delivery", ok, n); end
    src_valid = 1'b1;
    src_data  = 8'hFF;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk1);
      #0.1;
      vectors++;
      if (dst_valid !== 1'b1 || dst_data !== 8'h3C) begin
        miscompares++; bad++;
        if (bad < 4) $display("FAIL bp_hold got v=%b d=%h want v=1 d=3c", dst_valid, dst_data);
      end
    end
    vectors++;
    if (src_ready !== 1'b0) begin miscompares++; $display("FAIL bp_src_ready got %b want 0", src_ready); end
    src_valid = 1'b0;
    dst_ready = 1'b1;
    @(posedge clk1);
    #0.1;
    vectors++;
    if (dst_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release got %b want 0", dst_valid); end
    vectors++;
    if (xfer_cnt !== 8'd2) begin miscompares++; $display("FAIL bp_cnt got %0d want 2", xfer_cnt); end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk1);
      #0.1;
      if (dst_valid) n++;
    end
    vectors++;
    if (n != 0) begin miscompares++; $display("FAIL bp_once got %0d extra cycles want 0", n); end
    vectors++;
    if (src_ready !== 1'b1) begin miscompares++; $display("FAIL bp_src_return got %b want 1", src_ready); end
  endtask

  task automatic test_reset_midflight();
    bit ok;
    int n;
    dst_ready = 1'b1;
    send_word(8'h77, ok);
    @(posedge clk1);
    #0.1;
    reset_n = 1'b0;
    #0.1;
    vectors++;
    if (src_ready !== 1'b1 || dst_valid !== 1'b0 || xfer_cnt !== 8'd0 || dst_data !== 8'h00) begin
      miscompares++;
      $display("FAIL midrst_values got rdy=%b v=%b cnt=%0d d=%h want 1 0 0 00", src_ready, dst_valid, xfer_cnt, dst_data);
    end
    repeat (3) @(posedge clk1);
    #0.1;
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk1);
      #0.1;
      if (dst_valid) n++;
    end
    vectors++;
    if (n != 0) begin miscompares++; $display("FAIL midrst_aborted got %0d valid cycles want 0", n); end
    send_word(8'h5A, ok);
    wait_dst(n);
    vectors++;
    if (!ok || n == 0 || dst_data !== 8'h5A) begin
      miscompares++; $display("FAIL midrst_next got n=%0d d=%h want 5a", n, dst_data);
    end
    @(posedge clk1);
    #0.1;
    vectors++;
    if (xfer_cnt !== 8'd1) begin miscompares++; $display("FAIL midrst_cnt got %0d want 1", xfer_cnt); end
  endtask

  task automatic test_parity();
    bit ok;
    int n;
    dst_ready = 1'b0;
`ifdef CDC_PARITY_EN
    send_word(8'h81, ok);
    force dut.hold_data = 8'h91;
    wait_dst(n);
    vectors++;
    if (!ok || n == 0 || dst_perr !== 1'b1 || dst_data !== 8'h91) begin
      miscompares++; $display("FAIL parity_err got perr=%b d=%h want perr=1 d=91", dst_perr, dst_data);
    end
    release dut.hold_data;
    dst_ready = 1'b1;
    @(posedge clk1);
    #0.1;
    dst_ready = 1'b0;
    send_word(8'h3F, ok);
    wait_dst(n);
    vectors++;
    if (!ok || n == 0 || dst_perr !== 1'b0 || dst_data !== 8'h3F) begin
      miscompares++; $display("FAIL parity_clean got perr=%b d=%h want perr=0 d=3f", dst_perr, dst_data);
    end
`else
    send_word(8'hA7, ok);
    wait_dst(n);
    vectors++;
    if (!ok || n == 0 || dst_perr !== 1'b0 || dst_data !== 8'hA7) begin
      miscompares++; $display("FAIL parity_off got perr=%b d=%h want perr=0 d=a7", dst_perr, dst_data);
    end
`endif
    dst_ready = 1'b1;
    @(posedge clk1);
    #0.1;
  endtask

  task automatic test_stream(input realtime p1, input realtime p2);
    logic [7:0] exp_w [N_STR];
    int rx;
    int extra;
    h1 = p1;
    h2 = p2;
    for (int i = 0; i < N_STR; i++) exp_w[i] = 8'($urandom);
    dst_ready = 1'b1;
    apply_reset();
    rx = 0;
    fork
      begin
        int idx;
        int guard;
        bit acc;
        idx = 0;
        guard = 0;
        @(posedge clk2);
        #0.1;
        src_valid = 1'b1;
        src_data  = exp_w[0];
        while (idx < N_STR && guard < 20000) begin
          acc = src_ready;
          @(posedge clk2);
          #0.1;
          guard++;
          if (acc) begin
            idx++;
            if (idx < N_STR) src_data = exp_w[idx];
          end
        end
        src_valid = 1'b0;
      end
      begin
        int cyc;
        cyc = 0;
        while (rx < N_STR && cyc < 30000) begin
          @(posedge clk1);
          #0.1;
          cyc++;
          if (dst_valid) begin
            vectors++;
            if (dst_data !== exp_w[rx] || dst_perr !== 1'b0) begin
              miscompares++;
              $display("FAIL stream_word[%0d] got %h perr=%b want %h perr=0", rx, dst_data, dst_perr, exp_w[rx]);
            end
            rx++;
          end
        end
      end
    join
    vectors++;
    if (rx != N_STR) begin miscompares++; $display("FAIL stream_count got %0d words want %0d", rx, N_STR); end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk1);
      #0.1;
      if (dst_valid) extra++;
    end
    vectors++;
    if (extra != 0) begin miscompares++; $display("FAIL stream_dup got %0d extra words want 0", extra); end
    vectors++;
    if (xfer_cnt !== 8'd44) begin miscompares++; $display("FAIL stream_cnt got %0d want 44", xfer_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_reset_midflight();
    test_parity();
    test_stream(5.0, 6.5);
    test_stream(6.5, 5.0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
